// File: rtl/instr_fetch_unit.sv
// Fetch front end: owns the PC, issues req/gnt/rvalid word fetches and buffers responses for the decoder.
// Optional macro IFU_MISALIGN_CHECK_EN adds misalign_o, pulsed when a redirect target is not word aligned.
module instr_fetch_unit #(
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_en_i,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i,
  input  logic        pc_mux_i,
  input  logic [31:0] jump_target_i
`ifdef IFU_MISALIGN_CHECK_EN
  ,
  output logic        misalign_o
`endif
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(FIFO_DEPTH);

  typedef enum logic {IDLE, RUN} state_e;

  state_e           state_q, state_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] outst_q, outst_d;
  logic [CNT_W-1:0] disc_q, disc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic             pend_q, pend_d;
  logic [31:0]      fdata_q [FIFO_DEPTH];
  logic [31:0]      fdata_d [FIFO_DEPTH];
  logic [31:0]      fpc_q   [FIFO_DEPTH];
  logic [31:0]      fpc_d   [FIFO_DEPTH];

  logic [31:0]      target;
  logic [CNT_W-1:0] inflight;
  logic             req, grant, drop, push, pop;

  assign target   = {jump_target_i[31:2], 2'b00};
  assign inflight = outst_q + cnt_q;
  // pend_q keeps an un-granted request alive even after fetch_en_i drops
  assign req      = (state_q == RUN) && (fetch_en_i || pend_q) && (inflight < DEPTH);
  assign grant    = req && instr_gnt_i;
  assign drop     = instr_rvalid_i && (pc_mux_i || (disc_q != '0));
  assign push     = instr_rvalid_i && !drop;
  assign pop      = (cnt_q != '0) && instr_ready_i;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (fetch_en_i) state_d = RUN;
      RUN: begin
        if (!fetch_en_i && (pc_mux_i || !(req && !instr_gnt_i))) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    outst_d    = outst_q + CNT_W'(grant) - CNT_W'(instr_rvalid_i);
    disc_d     = disc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    fdata_d    = fdata_q;
    fpc_d      = fpc_q;
    pend_d     = req && !instr_gnt_i;
    cnt_d      = cnt_q + CNT_W'(push) - CNT_W'(pop);

    if (grant) fetch_pc_d = fetch_pc_q + 32'd4;
    if (push) begin
      fdata_d[wr_ptr_q] = instr_rdata_i;
      fpc_d[wr_ptr_q]   = resp_pc_q;
      wr_ptr_d          = wr_ptr_q + 1'b1;
      resp_pc_d         = resp_pc_q + 32'd4;
    end
    if (instr_rvalid_i && (disc_q != '0)) disc_d = disc_q - 1'b1;
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

    // Redirect: everything still in flight (including a same-cycle grant) becomes stale
    if (pc_mux_i) begin
      fetch_pc_d = target;
      resp_pc_d  = target;
      disc_d     = outst_d;
      cnt_d      = '0;
      rd_ptr_d   = wr_ptr_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      fetch_pc_q <= BOOT_ADDR;
      resp_pc_q  <= BOOT_ADDR;
      outst_q    <= '0;
      disc_q     <= '0;
      cnt_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      pend_q     <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fdata_q[i] <= '0;
        fpc_q[i]   <= BOOT_ADDR;
      end
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      outst_q    <= outst_d;
      disc_q     <= disc_d;
      cnt_q      <= cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      pend_q     <= pend_d;
      fdata_q    <= fdata_d;
      fpc_q      <= fpc_d;
    end
  end

  assign instr_req_o   = req;
  assign instr_addr_o  = fetch_pc_q;
  assign instr_valid_o = (cnt_q != '0);
  assign instr_o       = fdata_q[rd_ptr_q];
  assign instr_pc_o    = fpc_q[rd_ptr_q];

`ifdef IFU_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  assign misalign_d = pc_mux_i && (jump_target_i[1:0] != 2'b00);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) misalign_q <= 1'b0;
    else         misalign_q <= misalign_d;
  end

  assign misalign_o = misalign_q;
`else
  logic unused_tgt_lsb;
  assign unused_tgt_lsb = ^jump_target_i[1:0];
`endif

endmodule
